// File: rtl/bcd_seg7_mux_driver_if.sv
// bcd_seg7_mux_driver_if
// Bundles the digit-pair input and the display output of the 7-segment
// multiplexer so producer, driver and bench share one set of wires.
//   upper, lower : BCD digit pair from the binary-to-BCD converter
//   load         : capture strobe for upper/lower
//   seg          : segments {g,f,e,d,c,b,a}, active-low
//   an           : anodes, active-low; an[0] lower digit, an[1] upper digit
// Modports: master = digit producer (drives digits, observes display),
//           slave  = display driver.
interface bcd_seg7_mux_driver_if;
    logic [3:0] upper;
    logic [3:0] lower;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output upper,
        output lower,
        output load,
        input  seg,
        input  an
    );

    modport slave (
        input  upper,
        input  lower,
        input  load,
        output seg,
        output an
    );
endinterface

// File: rtl/bcd_seg7_mux_driver.sv
// bcd_seg7_mux_driver
// Time-multiplexes a captured BCD digit pair onto a 2-digit common-anode
// 7-segment display. Each digit owns a slot of REFRESH_DIV cycles; the first
// BLANK_CYC cycles of every slot keep both anodes off to avoid ghosting.
// Codes 10..15 are shown as '-'.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_seg7_mux_driver_if.slave (upper, lower, load in; seg, an out)
// Parameters:
//   REFRESH_DIV : clock cycles per digit slot (>= 2)
//   BLANK_CYC   : guard cycles at slot start (0 <= BLANK_CYC < REFRESH_DIV)
// Optional feature macro:
//   SEG7_LZ_BLANK_EN : when defined, a zero upper digit is suppressed
//                      (UPPER slot stays dark); slot timing is unchanged.
module bcd_seg7_mux_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_seg7_mux_driver_if.slave   bus
);

    localparam int             CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);
    localparam logic [1:0]     AN_OFF    = 2'b11;
    localparam logic [1:0]     AN_LOWER  = 2'b10;
    localparam logic [1:0]     AN_UPPER  = 2'b01;
    localparam logic [6:0]     SEG_OFF   = 7'h7F;

    typedef enum logic {
        SLOT_LOWER = 1'b0,
        SLOT_UPPER = 1'b1
    } slot_t;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    slot_t         sel;
    slot_t         sel_next;
    logic [3:0]    up_q;
    logic [3:0]    lo_q;
    logic [6:0]    seg_q;
    logic [6:0]    seg_next;
    logic [1:0]    an_q;
    logic [1:0]    an_next;

    // Active-high segment pattern {g..a}; anything that is not BCD shows '-'.
    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b1000000;
        endcase
        return p;
    endfunction

    // Digit capture: the display works from held copies so upstream logic
    // may change freely between load strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q <= 4'd0;
            lo_q <= 4'd0;
        end else if (bus.load) begin
            up_q <= bus.upper;
            lo_q <= bus.lower;
        end
    end

    // Prescaler, slot selection and output decode. Outputs are derived from
    // the next-state counter/slot so they switch on the same edge as the
    // state, while using the previously captured digits.
    always_comb begin
        cnt_next = cnt + 1'b1;
        sel_next = sel;
        an_next  = AN_OFF;
        seg_next = SEG_OFF;

        if (cnt == CNT_LAST) begin
            cnt_next = '0;
            sel_next = (sel == SLOT_LOWER) ? SLOT_UPPER : SLOT_LOWER;
        end

        if (cnt_next >= BLANK_END) begin
            if (sel_next == SLOT_LOWER) begin
                an_next  = AN_LOWER;
                seg_next = ~dec(lo_q);
            end else begin
`ifdef SEG7_LZ_BLANK_EN
                // Leading-zero suppression: a zero tens digit stays dark.
                if (up_q != 4'd0) begin
                    an_next  = AN_UPPER;
                    seg_next = ~dec(up_q);
                end
`else
                an_next  = AN_UPPER;
                seg_next = ~dec(up_q);
`endif
            end
        end
    end

    // State and registered outputs; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sel   <= SLOT_LOWER;
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
        end else begin
            cnt   <= cnt_next;
            sel   <= sel_next;
            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule
